// File: rtl/hour_counter_cfg.sv
// Hour counter with preset load, 12/24h BCD display and day carry/borrow pulses.
// All state lives on clk; incoming strobes are plain clock enables.
module hour_counter_cfg #(
    parameter int unsigned HOURS_PER_DAY = 24,
    parameter int unsigned W             = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_hour,
    input  logic         dec_hour,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         mode_12h,
    output logic [W-1:0] o_hour,
    output logic [7:0]   o_hour_bcd,
    output logic         o_pm,
    output logic         o_day_carry,
    output logic         o_day_borrow,
    output logic         o_load_err
);

    localparam logic [W-1:0] MAX_CNT = W'(HOURS_PER_DAY - 1);
    localparam logic [W:0]   HPD_EXT = (W+1)'(HOURS_PER_DAY);
    localparam logic         MODE_OK = 1'(HOURS_PER_DAY == 24);

    if (HOURS_PER_DAY < 2 || HOURS_PER_DAY > 99 || (64'd1 << W) < 64'(HOURS_PER_DAY))
    begin : gen_bad_param
        $error("hour_counter_cfg: illegal HOURS_PER_DAY/W combination");
    end

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    logic [W-1:0] cnt_q, cnt_d;
    logic         carry_d, borrow_d, err_d;
    logic [7:0]   bcd_q, bcd_d;
    logic         pm_q, pm_d;
    logic         carry_q, borrow_q, err_q;
    logic         mode_eff;
    logic [6:0]   disp_val;
    logic [6:0]   h12;

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (load) begin
            // Out-of-range presets are rejected before they can reach cnt.
            if ({1'b0, load_val} < HPD_EXT) begin
                cnt_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (inc_hour && !dec_hour) begin
            if (cnt_q == MAX_CNT) begin
                cnt_d   = '0;
                carry_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec_hour && !inc_hour) begin
            if (cnt_q == '0) begin
                cnt_d    = MAX_CNT;
                borrow_d = 1'b1;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Display follows next-state cnt so it lines up with o_hour.
    always_comb begin
        mode_eff = mode_12h & MODE_OK;
        disp_val = 7'(cnt_d);
        h12      = (disp_val >= 7'd12) ? (disp_val - 7'd12) : disp_val;
        if (h12 == 7'd0) begin
            h12 = 7'd12;
        end
        if (mode_eff) begin
            bcd_d = to_bcd(h12);
            pm_d  = (disp_val >= 7'd12);
        end else begin
            bcd_d = to_bcd(disp_val);
            pm_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            bcd_q    <= 8'h00;
            pm_q     <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            pm_q     <= pm_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign o_hour       = cnt_q;
    assign o_hour_bcd   = bcd_q;
    assign o_pm         = pm_q;
    assign o_day_carry  = carry_q;
    assign o_day_borrow = borrow_q;
    assign o_load_err   = err_q;

endmodule

// File: tb/tb_hour_counter_cfg.sv
// Directed bench for hour_counter_cfg: 24h instance plus a 12-hour-modulus instance.
module tb_hour_counter_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_hour = 1'b0;
    logic       dec_hour = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;
    logic [3:0] load_val2 = '0;
    logic       mode_12h = 1'b0;

    logic [4:0] hour;
    logic [7:0] bcd;
    logic       pm, carry, borrow, err;
    logic [3:0] hour2;
    logic [7:0] bcd2;
    logic       pm2, carry2, borrow2, err2;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hour_counter_cfg #(.HOURS_PER_DAY(24), .W(5)) dut (
        .clk(clk), .rst_n(rst_n), .inc_hour(inc_hour), .dec_hour(dec_hour),
        .load(load), .load_val(load_val), .mode_12h(mode_12h),
        .o_hour(hour), .o_hour_bcd(bcd), .o_pm(pm),
        .o_day_carry(carry), .o_day_borrow(borrow), .o_load_err(err)
    );

    hour_counter_cfg #(.HOURS_PER_DAY(12), .W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .inc_hour(inc_hour), .dec_hour(dec_hour),
        .load(load), .load_val(load_val2), .mode_12h(mode_12h),
        .o_hour(hour2), .o_hour_bcd(bcd2), .o_pm(pm2),
        .o_day_carry(carry2), .o_day_borrow(borrow2), .o_load_err(err2)
    );

    // One rising edge, then sample 1 time unit later and drop the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        inc_hour = 1'b0;
        dec_hour = 1'b0;
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_run++;
        if ({hour, bcd, pm, carry, borrow, err} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_24: hour=%0d bcd=%h pm=%b c=%b b=%b e=%b, want all 0",
                     hour, bcd, pm, carry, borrow, err);
        end
        n_run++;
        if ({hour2, bcd2, pm2, carry2, borrow2, err2} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_12: hour=%0d bcd=%h pm=%b, want all 0", hour2, bcd2, pm2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd0 || bcd !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset: hour=%0d bcd=%h, want 0/00", hour, bcd);
        end
    endtask

    task automatic test_inc_wrap();
        for (int i = 1; i <= 23; i++) begin
            inc_hour = 1'b1;
            tick();
            n_run++;
            if (hour !== 5'(i) || carry !== 1'b0) begin
                n_fail++;
                $display("FAIL inc_step%0d: hour=%0d carry=%b, want %0d/0", i, hour, carry, i);
            end
        end
        n_run++;
        if (bcd !== 8'h23) begin
            n_fail++;
            $display("FAIL bcd_23: bcd=%h, want 23", bcd);
        end
        inc_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd0 || carry !== 1'b1 || bcd !== 8'h00) begin
            n_fail++;
            $display("FAIL inc_wrap: hour=%0d carry=%b bcd=%h, want 0/1/00", hour, carry, bcd);
        end
        tick();
        n_run++;
        if (carry !== 1'b0 || hour !== 5'd0) begin
            n_fail++;
            $display("FAIL carry_1cyc: carry=%b hour=%0d, want 0/0", carry, hour);
        end
    endtask

    task automatic test_dec_wrap();
        dec_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd23 || borrow !== 1'b1 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_wrap: hour=%0d borrow=%b carry=%b, want 23/1/0",
                     hour, borrow, carry);
        end
        inc_hour = 1'b1;
        dec_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd23 || borrow !== 1'b0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_dec_both: hour=%0d borrow=%b carry=%b, want 23/0/0",
                     hour, borrow, carry);
        end
        dec_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd22 || bcd !== 8'h22 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_plain: hour=%0d bcd=%h borrow=%b, want 22/22/0", hour, bcd, borrow);
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 5'd17; inc_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd17 || carry !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_17: hour=%0d carry=%b err=%b, want 17/0/0", hour, carry, err);
        end
        load = 1'b1; load_val = 5'd25;
        tick();
        n_run++;
        if (hour !== 5'd17 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL load_25: hour=%0d err=%b, want 17/1", hour, err);
        end
        load = 1'b1; load_val = 5'd24;
        tick();
        n_run++;
        if (hour !== 5'd17 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL load_24: hour=%0d err=%b, want 17/1", hour, err);
        end
        load = 1'b1; load_val = 5'd23; dec_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd23 || err !== 1'b0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL load_23: hour=%0d err=%b borrow=%b, want 23/0/0", hour, err, borrow);
        end
    endtask

    task automatic test_back_to_back();
        inc_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd0 || carry !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_carry: hour=%0d carry=%b, want 0/1", hour, carry);
        end
        dec_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd23 || borrow !== 1'b1 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_borrow: hour=%0d borrow=%b carry=%b, want 23/1/0",
                     hour, borrow, carry);
        end
        inc_hour = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd0 || carry !== 1'b1 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_carry2: hour=%0d carry=%b borrow=%b, want 0/1/0",
                     hour, carry, borrow);
        end
    endtask

    task automatic test_12h();
        logic [7:0] exp12 [24];
        exp12 = '{8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h01, 8'h02, 8'h03,
                  8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11};
        mode_12h = 1'b1;
        load = 1'b1; load_val = 5'd0;
        tick();
        n_run++;
        if (hour !== 5'd0 || bcd !== 8'h12 || pm !== 1'b0) begin
            n_fail++;
            $display("FAIL h12_midnight: hour=%0d bcd=%h pm=%b, want 0/12/0", hour, bcd, pm);
        end
        for (int i = 1; i < 24; i++) begin
            inc_hour = 1'b1;
            tick();
            n_run++;
            if (hour !== 5'(i) || bcd !== exp12[i] || pm !== (i >= 12)) begin
                n_fail++;
                $display("FAIL h12_sweep%0d: hour=%0d bcd=%h pm=%b, want %0d/%h/%0d",
                         i, hour, bcd, pm, i, exp12[i], (i >= 12));
            end
        end
        load = 1'b1; load_val = 5'd15;
        tick();
        n_run++;
        if (bcd !== 8'h03 || pm !== 1'b1) begin
            n_fail++;
            $display("FAIL h12_15: bcd=%h pm=%b, want 03/1", bcd, pm);
        end
        mode_12h = 1'b0;
        #2;
        n_run++;
        if (bcd !== 8'h03) begin
            n_fail++;
            $display("FAIL mode_lag: bcd=%h, want 03 before edge", bcd);
        end
        tick();
        n_run++;
        if (hour !== 5'd15 || bcd !== 8'h15 || pm !== 1'b0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_toggle: hour=%0d bcd=%h pm=%b carry=%b, want 15/15/0/0",
                     hour, bcd, pm, carry);
        end
    endtask

    task automatic test_hpd12();
        mode_12h = 1'b1;
        load = 1'b1; load_val = 5'd5; load_val2 = 4'd11;
        tick();
        n_run++;
        if (hour2 !== 4'd11 || bcd2 !== 8'h11 || pm2 !== 1'b0) begin
            n_fail++;
            $display("FAIL m12_load11: hour=%0d bcd=%h pm=%b, want 11/11/0", hour2, bcd2, pm2);
        end
        load = 1'b1; load_val2 = 4'd12;
        tick();
        n_run++;
        if (hour2 !== 4'd11 || err2 !== 1'b1) begin
            n_fail++;
            $display("FAIL m12_load12: hour=%0d err=%b, want 11/1", hour2, err2);
        end
        inc_hour = 1'b1;
        tick();
        n_run++;
        if (hour2 !== 4'd0 || carry2 !== 1'b1 || bcd2 !== 8'h00 || pm2 !== 1'b0) begin
            n_fail++;
            $display("FAIL m12_wrap: hour=%0d carry=%b bcd=%h pm=%b, want 0/1/00/0",
                     hour2, carry2, bcd2, pm2);
        end
        dec_hour = 1'b1;
        tick();
        n_run++;
        if (hour2 !== 4'd11 || borrow2 !== 1'b1 || carry2 !== 1'b0) begin
            n_fail++;
            $display("FAIL m12_borrow: hour=%0d borrow=%b carry=%b, want 11/1/0",
                     hour2, borrow2, carry2);
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_reset_midwrap();
        load = 1'b1; load_val = 5'd23;
        tick();
        inc_hour = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({hour, bcd, pm, carry, borrow, err} !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset: hour=%0d bcd=%h pm=%b c=%b b=%b e=%b, want all 0",
                     hour, bcd, pm, carry, borrow, err);
        end
        @(posedge clk);
        #1;
        inc_hour = 1'b0;
        n_run++;
        if (hour !== 5'd0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: hour=%0d carry=%b, want 0/0", hour, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_run++;
        if (hour !== 5'd0 || carry !== 1'b0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL no_carry_after_reset: hour=%0d carry=%b borrow=%b, want 0/0/0",
                     hour, carry, borrow);
        end
        mode_12h = 1'b1;
        tick();
        n_run++;
        if (bcd !== 8'h12 || pm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_12h_disp: bcd=%h pm=%b, want 12/0", bcd, pm);
        end
        mode_12h = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_dec_wrap();
        test_load();
        test_back_to_back();
        test_12h();
        test_hpd12();
        test_reset_midwrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hour_counter_cfg.md
# hour_counter_cfg

Parametrised, synchronous hour counter for the clock datapath. It counts 0..HOURS_PER_DAY-1 on single-cycle increment strobes from the minutes stage and on decrement strobes from user adjust. It supports a synchronous preset load and an optional 12-hour display mode with an AM/PM flag and BCD output. It emits registered one-cycle day carry/borrow pulses to the day stage. It replaces ripple-clocked hour counting: everything runs on `clk`, and strobes are treated as enables.

## Interface
- HOURS_PER_DAY, 24, modulus of the counter; legal range 2..99.
- W, 5, width of the binary count; must satisfy 2^W >= HOURS_PER_DAY.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- inc_hour  input  1  single-cycle increment strobe.
- dec_hour  input  1  single-cycle decrement strobe.
- load  input  1  synchronous preset strobe.
- load_val  input  W  preset value, binary, 24-hour domain.
- mode_12h  input  1  selects 12-hour display; only honoured when HOURS_PER_DAY == 24, otherwise ignored (treated as 0).
- o_hour  output  W  binary count, always in the 0..HOURS_PER_DAY-1 domain.
- o_hour_bcd  output  8  display hour, two BCD digits.
- o_pm  output  1  PM flag; valid in 12h mode, 0 otherwise.
- o_day_carry  output  1  one-cycle pulse on forward wrap.
- o_day_borrow  output  1  one-cycle pulse on backward wrap.
- o_load_err  output  1  one-cycle pulse when a load is rejected.

## Operation
- Internal count `cnt` (W bits) is the only architectural state. All outputs are registered.
- Per-cycle priority is load > (inc XOR dec) > hold.
- **load:**
  - If load_val < HOURS_PER_DAY: `cnt` <= load_val. No carry or borrow.
  - Otherwise: `cnt` is unchanged and o_load_err pulses.
  - inc/dec in the same cycle are discarded.
- **inc only:**
  - If `cnt` == HOURS_PER_DAY-1: `cnt` <= 0 and o_day_carry pulses.
  - Else `cnt` <= `cnt`+1.
- **dec only:**
  - If `cnt` == 0: `cnt` <= HOURS_PER_DAY-1 and o_day_borrow pulses.
  - Else `cnt` <= `cnt`-1.
- **inc and dec together:** no change, no pulses.
- **Display, 24h mode:**
  - o_hour_bcd = BCD(`cnt`).
  - o_pm = 0.
- **Display, 12h mode:**
  - h12 = `cnt` mod 12, with 0 mapped to 12.
  - o_hour_bcd = BCD(h12).
  - o_pm = (`cnt` >= 12).
  - Examples: `cnt` 0 -> 0x12 AM; 12 -> 0x12 PM; 13 -> 0x01 PM; 23 -> 0x11 PM.
- Display registers are recomputed every cycle from next-state `cnt` and the current mode_12h. A mode change alone updates the display one cycle later without touching `cnt`.
- Arithmetic:
  - Comparisons are unsigned at W bits.
  - No intermediate value exceeds HOURS_PER_DAY-1 except load_val, which is range-checked before use.
- Pulse outputs are high for exactly one cycle per qualifying event. Back-to-back events give back-to-back pulses.

## Timing
- Latency is 1 cycle: a strobe sampled at edge N is reflected on o_hour, o_hour_bcd, o_pm and any pulse output after edge N.
- o_day_carry is high in the same cycle that o_hour first shows 0 after a forward wrap. o_day_borrow behaves the same way for a backward wrap.
- No handshake: the upstream stage guarantees strobes are one cycle wide. A strobe held high counts once per cycle.
- **Reset (asynchronous assert, any time, including mid-wrap):**
  - o_hour = 0, o_hour_bcd = 0x00, o_pm = 0.
  - o_day_carry = 0, o_day_borrow = 0, o_load_err = 0.
  - Pending pulses are cancelled.
- **After reset release:**
  - Strobes are honoured from the first rising edge.
  - On that first edge the display resolves to 0x12 if mode_12h is set, otherwise 0x00.
- mode_12h may change on any cycle. It never generates carry or borrow.

## Test plan
- Reset, then 23 inc strobes -> o_hour 23, bcd 0x23. 24th inc -> o_hour 0, o_day_carry high exactly 1 cycle, coincident with o_hour 0.
- From 0, a single dec -> o_hour 23, o_day_borrow 1-cycle pulse. Then inc and dec together -> o_hour stays 23, no pulses.
- load with load_val 17 while inc is high -> o_hour 17, no carry. load with load_val 25 -> o_hour unchanged, o_load_err 1-cycle pulse.
- mode_12h=1: sweep `cnt` 0..23 -> bcd/pm read 12A, 1A..11A, 12P, 1P..11P. Toggle mode at `cnt` 15 -> bcd goes 0x03 -> 0x15 one cycle later, o_hour unchanged.
- HOURS_PER_DAY=12, W=4, mode_12h=1 -> mode ignored; 11 -> 0 wrap with carry; bcd 0x11 -> 0x00, o_pm 0.
- Assert rst_n low asynchronously in the cycle the carry pulse is due (`cnt` 23 + inc) -> all outputs 0 immediately, no carry pulse after release.
